// File: rtl/btn_move_if.sv
// ============================================================================
// btn_move_if : raw board buttons in, conditioned move/tick/reset outputs out
// Revision 1.0
// ============================================================================
`default_nettype none

interface btn_move_if;
    logic       btnU;
    logic       btnD;
    logic       btnL;
    logic       btnR;
    logic       btnS;
    logic [4:0] o_btn_db;
    logic       o_tick;
    logic       o_move_valid;
    logic [1:0] o_dir;
    logic       o_game_rst;

    modport master (
        output btnU, btnD, btnL, btnR, btnS,
        input  o_btn_db, o_tick, o_move_valid, o_dir, o_game_rst
    );

    modport slave (
        input  btnU, btnD, btnL, btnR, btnS,
        output o_btn_db, o_tick, o_move_valid, o_dir, o_game_rst
    );
endinterface

`default_nettype wire

// File: rtl/btn_move_ctrl.sv
// ============================================================================
// btn_move_ctrl : button sync/debounce, game tick, one move command per tick
// Revision 1.0
// ============================================================================
`default_nettype none

module btn_move_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int TICK_CYCLES     = 5_000_000
) (
    input  wire logic   clk,
    input  wire logic   rst,
    btn_move_if.slave   bus
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
    localparam int TK_W = $clog2(TICK_CYCLES);
    localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TK_W-1:0] TK_MAX = TK_W'(TICK_CYCLES - 1);

    logic [4:0]      raw;
    logic [4:0]      sync1;
    logic [4:0]      sync2;
    logic [4:0]      stable;
    logic [4:0]      db;
    logic [4:0]      db_d;
    logic [4:0]      press;
    logic [TK_W-1:0] tick_cnt;
    logic            tick_now;
    logic            pending;
    logic [1:0]      pend_dir;
    logic            issue;
    logic [1:0]      issue_dir;
    logic            tick_r;
    logic            move_valid_r;
    logic [1:0]      dir_r;
    logic            game_rst_r;

    function automatic logic [1:0] prio_dir(input logic [3:0] d);
        if (d[0])      return 2'd0;
        else if (d[1]) return 2'd1;
        else if (d[2]) return 2'd2;
        else           return 2'd3;
    endfunction

    assign raw = {bus.btnS, bus.btnR, bus.btnL, bus.btnD, bus.btnU};

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Any return to the stable level before the count expires restarts it.
    for (genvar i = 0; i < 5; i++) begin : g_btn
        logic [DB_W-1:0] cnt;
        logic            st;

        always_ff @(posedge clk) begin
            if (rst) begin
                cnt <= '0;
                st  <= 1'b0;
            end else if (sync2[i] == st) begin
                cnt <= '0;
            end else if (cnt == DB_MAX) begin
                cnt <= '0;
                st  <= sync2[i];
            end else begin
                cnt <= cnt + 1'b1;
            end
        end

        assign stable[i] = st;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            db   <= '0;
            db_d <= '0;
        end else begin
            db   <= stable;
            db_d <= db;
        end
    end

    assign press = db & ~db_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt <= '0;
        end else if (tick_now) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    assign tick_now = (tick_cnt == TK_MAX);

    // A press landing in the tick cycle survives into the next tick period.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending  <= 1'b0;
            pend_dir <= 2'd0;
        end else if (db[4]) begin
            pending  <= 1'b0;
        end else if (|press[3:0]) begin
            pending  <= 1'b1;
            pend_dir <= prio_dir(press[3:0]);
        end else if (tick_now) begin
            pending  <= 1'b0;
        end
    end

    always_comb begin
        issue     = 1'b0;
        issue_dir = pend_dir;
        if (tick_now && !db[4]) begin
            if (|db[3:0]) begin
                issue     = 1'b1;
                issue_dir = prio_dir(db[3:0]);
            end else if (pending) begin
                issue     = 1'b1;
                issue_dir = pend_dir;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_r       <= 1'b0;
            move_valid_r <= 1'b0;
            dir_r        <= 2'd0;
            game_rst_r   <= 1'b0;
        end else begin
            tick_r       <= tick_now;
            move_valid_r <= issue;
            game_rst_r   <= press[4];
            if (issue) begin
                dir_r <= issue_dir;
            end
        end
    end

    assign bus.o_btn_db     = db;
    assign bus.o_tick       = tick_r;
    assign bus.o_move_valid = move_valid_r;
    assign bus.o_dir        = dir_r;
    assign bus.o_game_rst   = game_rst_r;

endmodule

`default_nettype wire

// File: tb/tb_btn_move_ctrl.sv
// ============================================================================
// tb_btn_move_ctrl : directed self-checking bench for btn_move_ctrl
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_btn_move_ctrl;

    localparam int DB = 4;
    localparam int TK = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   k        = 0;

    btn_move_if bus();

    btn_move_ctrl #(
        .DEBOUNCE_CYCLES (DB),
        .TICK_CYCLES     (TK)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // k counts clock edges since the last reset release.
    task automatic step();
        @(posedge clk);
        #1;
        k++;
    endtask

    task automatic wait_align();
        while (k % TK != 0) step();
    endtask

    task automatic test_reset();
        logic [9:0] outs;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            outs = {bus.o_btn_db, bus.o_tick, bus.o_move_valid, bus.o_dir, bus.o_game_rst};
            n_checks++;
            if (outs !== 10'd0) begin
                n_fail++;
                $display("FAIL reset_outputs: got %b expected %b", outs, 10'd0);
            end
        end
        rst = 1'b0;
        k   = 0;
        for (int i = 1; i <= 35; i++) begin
            step();
            n_checks++;
            if (bus.o_tick !== (k % TK == 0)) begin
                n_fail++;
                $display("FAIL tick_period k=%0d: got %b expected %b", k, bus.o_tick, (k % TK == 0));
            end
            n_checks++;
            if (bus.o_move_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_move k=%0d: got %b expected 0", k, bus.o_move_valid);
            end
        end
    endtask

    task automatic test_debounce();
        bus.btnU = 1'b1;
        for (int j = 1; j <= 3; j++) step();
        bus.btnU = 1'b0;
        for (int j = 1; j <= 10; j++) begin
            step();
            n_checks++;
            if (bus.o_btn_db[0] !== 1'b0) begin
                n_fail++;
                $display("FAIL glitch_reject j=%0d: got %b expected 0", j, bus.o_btn_db[0]);
            end
        end
        bus.btnU = 1'b1;
        for (int j = 1; j <= 20; j++) begin
            step();
            n_checks++;
            if (bus.o_btn_db[0] !== (j >= 7)) begin
                n_fail++;
                $display("FAIL db_rise j=%0d: got %b expected %b", j, bus.o_btn_db[0], (j >= 7));
            end
        end
        bus.btnU = 1'b0;
        for (int j = 1; j <= 10; j++) begin
            step();
            n_checks++;
            if (bus.o_btn_db[0] !== (j < 7)) begin
                n_fail++;
                $display("FAIL db_fall j=%0d: got %b expected %b", j, bus.o_btn_db[0], (j < 7));
            end
        end
    endtask

    task automatic check_held(input logic [1:0] exp_dir, input string name);
        for (int j = 0; j < 30; j++) begin
            step();
            n_checks++;
            if (bus.o_move_valid !== (k % TK == 0)) begin
                n_fail++;
                $display("FAIL %s_valid k=%0d: got %b expected %b", name, k, bus.o_move_valid, (k % TK == 0));
            end
            if (k % TK == 0) begin
                n_checks++;
                if (bus.o_dir !== exp_dir) begin
                    n_fail++;
                    $display("FAIL %s_dir k=%0d: got %b expected %b", name, k, bus.o_dir, exp_dir);
                end
            end
        end
    endtask

    task automatic test_held_priority();
        bus.btnR = 1'b1;
        bus.btnD = 1'b1;
        for (int j = 0; j < 8; j++) step();
        check_held(2'b01, "held_DR");
        bus.btnD = 1'b0;
        for (int j = 0; j < 8; j++) step();
        check_held(2'b11, "held_R");
        bus.btnR = 1'b0;
        for (int j = 0; j < 10; j++) step();
    endtask

    task automatic test_tap();
        int t;
        wait_align();
        t = k;
        for (int j = 0; j < 3; j++) step();
        bus.btnL = 1'b1;
        for (int j = 0; j < 8; j++) step();
        bus.btnL = 1'b0;
        while (k < t + 35) begin
            step();
            n_checks++;
            if (bus.o_move_valid !== (k == t + 20)) begin
                n_fail++;
                $display("FAIL tap_valid rel=%0d: got %b expected %b", k - t, bus.o_move_valid, (k == t + 20));
            end
            if (k == t + 20) begin
                n_checks++;
                if (bus.o_dir !== 2'b10) begin
                    n_fail++;
                    $display("FAIL tap_dir: got %b expected 10", bus.o_dir);
                end
            end
        end
    endtask

    task automatic test_game_reset();
        int t;
        bus.btnU = 1'b1;
        for (int j = 0; j < 20; j++) step();
        wait_align();
        t = k;
        bus.btnS = 1'b1;
        while (k < t + 45) begin
            if (k == t + 25) bus.btnS = 1'b0;
            step();
            n_checks++;
            if (bus.o_game_rst !== (k == t + 8)) begin
                n_fail++;
                $display("FAIL game_rst rel=%0d: got %b expected %b", k - t, bus.o_game_rst, (k == t + 8));
            end
            n_checks++;
            if (bus.o_move_valid !== (k == t + 40)) begin
                n_fail++;
                $display("FAIL s_suppress rel=%0d: got %b expected %b", k - t, bus.o_move_valid, (k == t + 40));
            end
            if (k == t + 40) begin
                n_checks++;
                if (bus.o_dir !== 2'b00) begin
                    n_fail++;
                    $display("FAIL s_resume_dir: got %b expected 00", bus.o_dir);
                end
            end
        end
        bus.btnU = 1'b0;
        for (int j = 0; j < 10; j++) step();
    endtask

    task automatic test_reset_mid();
        wait_align();
        for (int j = 0; j < 9; j++) step();
        bus.btnU = 1'b1;
        for (int j = 0; j < 8; j++) step();
        bus.btnU = 1'b0;
        rst = 1'b1;
        step();
        n_checks++;
        if ({bus.o_btn_db, bus.o_tick, bus.o_move_valid, bus.o_game_rst} !== 8'd0) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: got %b expected 0",
                     {bus.o_btn_db, bus.o_tick, bus.o_move_valid, bus.o_game_rst});
        end
        rst = 1'b0;
        k   = 0;
        for (int j = 1; j <= 25; j++) begin
            step();
            n_checks++;
            if (bus.o_tick !== (k % TK == 0)) begin
                n_fail++;
                $display("FAIL mid_tick k=%0d: got %b expected %b", k, bus.o_tick, (k % TK == 0));
            end
            n_checks++;
            if (bus.o_move_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL mid_no_move k=%0d: got %b expected 0", k, bus.o_move_valid);
            end
        end
    endtask

    initial begin
        bus.btnU = 1'b0;
        bus.btnD = 1'b0;
        bus.btnL = 1'b0;
        bus.btnR = 1'b0;
        bus.btnS = 1'b0;
        test_reset();
        test_debounce();
        test_held_priority();
        test_tap();
        test_game_reset();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
